param_updown_counter: RTL and testbench

Parametrised up/down counter with modulus, generalising the team's 4-bit free-running sync-reset counter. It adds:
- count enable
- direction control
- parallel load
- wrap or saturate mode
- a terminal-count strobe
- a sticky overflow flag

Used as the general timer/event-count primitive in datapath and test-infrastructure blocks.

---
 rtl/counter_pkg.sv | 37 +++
 rtl/counter_prescaler.sv | 33 +++
 rtl/param_updown_counter.sv | 111 +++++++++++
 tb/tb_param_updown_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and elaboration helpers for the parametrised up/down counter
// and its optional enable prescaler.
package counter_pkg;

    // Behaviour at the end of the count range.
    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } count_mode_e;

    // Ceiling log2: number of bits needed to index n distinct values (0 for n<=1).
    function automatic int clog2(input longint unsigned n);
        int               r;
        longint unsigned  v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // True when the counter parameters describe a buildable configuration.
    function automatic bit params_ok(input int width,
                                     input longint unsigned modulus,
                                     input int prescale);
        bit ok;
        ok = (width >= 2) && (width <= 32);
        if (ok) begin
            ok = (modulus >= 2) && (modulus <= (64'd1 << width));
        end
        ok = ok && (prescale >= 1) && (prescale <= 65535);
        return ok;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: tick is high on every PRESCALE-th cycle in which en=1.
// The phase holds while en=0 and restarts on reset or clr. Only instantiated
// when PSC_DIV_EN is defined.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    // The enabled cycle that lands on the last phase is the one that steps.
    assign tick = (phase == LAST);

    // Phase counter: restart on reset/clr, advance only on enabled cycles.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + CW'(1);
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulus, parallel load, wrap/saturate
// mode, combinational terminal-count strobe and sticky overflow flag.
// Optional feature macro: PSC_DIV_EN (enable prescaler of ratio PRESCALE).
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    generate
        if (!params_ok(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
            $error("param_updown_counter: illegal WIDTH/MODULUS/PRESCALE");
        end
    endgenerate

    // Top of range truncated to WIDTH bits; MODULUS=2**WIDTH gives all ones.
    localparam longint unsigned MAX_FULL = MODULUS - 1;
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_FULL[WIDTH-1:0];

    logic             step_en;
    logic             at_max;
    logic             at_min;
    logic             boundary_step;
    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    count_mode_e      mode;

`ifdef PSC_DIV_EN
    logic tick;

    // A load restarts the prescaler phase so counting resumes cleanly.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (en),
        .tick  (tick)
    );

    assign step_en = en & tick;
`else
    assign step_en = en;
`endif

    assign mode   = count_mode_e'(sat);
    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

    // Terminal count: a step is requested at the end of range in its direction.
    assign tc = step_en & ((up & at_max) | (~up & at_min));

    // A load pre-empts the step, so it must not raise the overflow flag.
    assign boundary_step = tc & ~load;

    // Next count and next overflow flag; load beats step beats hold.
    always_comb begin
        count_next = count;
        ovf_next   = ovf;
        if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step_en) begin
            if (up) begin
                if (at_max) begin
                    count_next = (mode == SAT) ? count : '0;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    count_next = (mode == SAT) ? count : MAX_VAL;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
        // Setting wins over a same-cycle clear.
        if (boundary_step) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a vector table for the MODULUS=10
// instance, hand sequences for MODULUS=16 and for the prescaled instance.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [3:0] load_val;
    logic       clr_ovf;

    logic [3:0] cnt10, cnt16, cntp;
    logic       tc10, tc16, tcp;
    logic       ovf10, ovf16, ovfp;

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut10 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt10), .tc(tc10), .ovf(ovf10)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut16 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt16), .tc(tc16), .ovf(ovf16)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) dutp (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(cntp), .tc(tcp), .ovf(ovfp)
    );

    // Clock and initial input values
    always #5 clk = ~clk;

    typedef struct {
        logic       r, e, u, s, l;
        logic [3:0] lv;
        logic       c;
        bit         ct;     // check tc for this vector
        logic       tc;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic vec_t mk(logic r, logic e, logic u, logic s, logic l,
                                logic [3:0] lv, logic c, bit ct, logic tc,
                                logic [3:0] cnt, logic ovf);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.s = s; v.l = l; v.lv = lv; v.c = c;
        v.ct = ct; v.tc = tc; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: apply inputs just after the falling edge.
    task automatic drive(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input logic [3:0] lv, input logic c);
        @(negedge clk);
        reset = r; en = e; up = u; sat = s; load = l; load_val = lv; clr_ovf = c;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // One table vector against the MODULUS=10 instance.
    task automatic apply10(input vec_t v, input int idx);
        drive(v.r, v.e, v.u, v.s, v.l, v.lv, v.c);
        #1;
        if (v.ct) check($sformatf("v%0d tc10", idx), {31'b0, tc10}, {31'b0, v.tc});
        exp_q.push_back(v.cnt);
        after_edge();
        check($sformatf("v%0d count10", idx), {28'b0, cnt10}, {28'b0, exp_q.pop_front()});
        check($sformatf("v%0d ovf10", idx), {31'b0, ovf10}, {31'b0, v.ovf});
    endtask

    initial begin
        int         n_en;
        logic [3:0] exp_p;
        logic       en_pat [11];

        reset = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0;
        load_val = '0; clr_ovf = 1'b0;

        // Reset, then a full wrap cycle with MODULUS=10.
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, (i % 10) == 9,
                              4'((i + 1) % 10), i >= 9));
        end
        // Saturating down at zero; clear loses against a same-cycle boundary step.
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
        // Load clamp, load beating a step, saturate up, wrap down.
        vecs.push_back(mk(0, 0, 1, 0, 1, 13, 0, 1, 0, 9, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4, 0, 0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 5, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 9, 0, 1, 0, 9, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 9, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 9, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 8, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 1));

        foreach (vecs[i]) apply10(vecs[i], i);

        // MODULUS=16: natural binary wrap, then reset mid-count.
        drive(1, 0, 1, 0, 0, 0, 0);
        after_edge();
        check("m16 reset count", {28'b0, cnt16}, 32'd0);
        check("m16 reset ovf", {31'b0, ovf16}, 32'd0);
        drive(0, 0, 1, 0, 1, 15, 0);
        after_edge();
        check("m16 load15", {28'b0, cnt16}, 32'd15);
        drive(0, 1, 1, 0, 0, 0, 0);
        #1;
        check("m16 tc at 15", {31'b0, tc16}, 32'd1);
        after_edge();
        check("m16 wrap count", {28'b0, cnt16}, 32'd0);
        check("m16 wrap ovf", {31'b0, ovf16}, 32'd1);
        drive(0, 0, 1, 0, 1, 7, 0);
        after_edge();
        check("m16 load7", {28'b0, cnt16}, 32'd7);
        check("m16 ovf kept by load", {31'b0, ovf16}, 32'd1);
        drive(1, 1, 1, 0, 0, 0, 0);
        after_edge();
        check("m16 mid reset count", {28'b0, cnt16}, 32'd0);
        check("m16 mid reset ovf", {31'b0, ovf16}, 32'd0);

        // PRESCALE=3 instance: steps every third enabled cycle when divided.
        en_pat = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        drive(1, 0, 1, 0, 0, 0, 0);
        after_edge();
        check("psc reset count", {28'b0, cntp}, 32'd0);
        n_en = 0;
        for (int i = 0; i < 11; i++) begin
            drive(0, en_pat[i], 1, 0, 0, 0, 0);
            if (en_pat[i]) n_en++;
`ifdef PSC_DIV_EN
            exp_p = 4'(n_en / 3);
`else
            exp_p = 4'(n_en);
`endif
            after_edge();
            check($sformatf("psc cycle%0d count", i), {28'b0, cntp}, {28'b0, exp_p});
        end

        drive(0, 0, 1, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
